// File: rtl/minisys_mc_control_if.sv
// Memory/IO bus seen by the Minisys-1A multi-cycle controller: effective
// address and acknowledge in, one-hot access strobes out.
interface minisys_mc_control_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] Alu_result;
  logic              mem_ready;
  logic              MemRead;
  logic              MemWrite;
  logic              IORead;
  logic              IOWrite;

  modport master (
    input  Alu_result, mem_ready,
    output MemRead, MemWrite, IORead, IOWrite
  );

  modport slave (
    output Alu_result, mem_ready,
    input  MemRead, MemWrite, IORead, IOWrite
  );
endinterface

// File: rtl/minisys_mc_control.sv
// Multi-cycle control FSM for the Minisys-1A core: fetch/decode/execute/
// memory/writeback sequencing with bus wait states, mul/div stall and exceptions.
module minisys_mc_control #(
  parameter int               ADDR_W      = 32,
  parameter int               IO_HI_W     = 22,
  parameter logic [IO_HI_W-1:0] IO_HI_VAL = 22'h3FFFFF,
  parameter int               MD_CYCLES   = 32,
  parameter int               MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        rs_sign,
  input  logic        rs_zero,
  input  logic        ext_int,
  minisys_mc_control_if.master bus,
  output logic [2:0]  state,
  output logic        Wir,
  output logic        PcWrite,
  output logic [1:0]  Wpc,
  output logic        Waluresult,
  output logic        RegWrite,
  output logic        Busy,
  output logic        Exc,
  output logic [4:0]  ExcCode
);
  // state | meaning
  // SINIT | after reset, no activity
  // SIF   | fetch: load IR, PC <= PC+4
  // SID   | decode; jumps and traps resolved here
  // SEX   | execute; branches, alignment check, mul/div launch
  // SMEM  | bus access held until mem_ready or timeout
  // SWB   | register-file write
  // SMD   | mul/div stall
  // SEXC  | exception/interrupt entry pulse toward CP0
  typedef enum logic [2:0] {
    SINIT = 3'd0, SIF = 3'd1, SID = 3'd2, SEX = 3'd3,
    SMEM  = 3'd4, SWB = 3'd5, SMD = 3'd6, SEXC = 3'd7
  } state_t;

  localparam int CNT_MAX = (MD_CYCLES - 1 > MEM_TIMEOUT) ? MD_CYCLES - 1 : MEM_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [4:0]       code_q, code_nxt;

  logic [5:0] op, func;
  logic [4:0] rs, rt;
  assign op   = Instruction[31:26];
  assign rs   = Instruction[25:21];
  assign rt   = Instruction[20:16];
  assign func = Instruction[5:0];

  logic unused_bits;
  assign unused_bits = ^{Instruction[15:6], bus.Alu_result[ADDR_W-IO_HI_W-1:2]};

  logic valid, is_load, is_store, is_half, is_word, is_branch, br_link;
  logic is_jump, jmp_reg, jmp_link, is_md, no_wb, is_sys, is_brk, taken;

  always_comb begin
    valid = 1'b1; is_load = 1'b0; is_store = 1'b0; is_half = 1'b0; is_word = 1'b0;
    is_branch = 1'b0; br_link = 1'b0; is_jump = 1'b0; jmp_reg = 1'b0; jmp_link = 1'b0;
    is_md = 1'b0; no_wb = 1'b0; is_sys = 1'b0; is_brk = 1'b0;
    case (op)
      6'b000000: begin
        case (func)
          6'b001000: begin is_jump = 1'b1; jmp_reg = 1'b1; end
          6'b001001: begin is_jump = 1'b1; jmp_reg = 1'b1; jmp_link = 1'b1; end
          6'b001100: is_sys = 1'b1;
          6'b001101: is_brk = 1'b1;
          6'b010001, 6'b010011: no_wb = 1'b1;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: is_md = 1'b1;
          6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
          6'b010000, 6'b010010, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011: ;
          default: valid = 1'b0;
        endcase
      end
      6'b000001: begin
        is_branch = 1'b1;
        br_link   = rt[4];
        valid     = (rt == 5'b00000) || (rt == 5'b00001) ||
                    (rt == 5'b10000) || (rt == 5'b10001);
      end
      6'b000010: is_jump = 1'b1;
      6'b000011: begin is_jump = 1'b1; jmp_link = 1'b1; end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: is_branch = 1'b1;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: ;
      6'b010000: begin
        if (rs == 5'b00100) no_wb = 1'b1;
        else if (rs == 5'b10000 && func == 6'b011000) no_wb = 1'b1;
        else if (rs != 5'b00000) valid = 1'b0;
      end
      6'b100000, 6'b100100: is_load = 1'b1;
      6'b100001, 6'b100101: begin is_load = 1'b1; is_half = 1'b1; end
      6'b100011: begin is_load = 1'b1; is_word = 1'b1; end
      6'b101000: is_store = 1'b1;
      6'b101001: begin is_store = 1'b1; is_half = 1'b1; end
      6'b101011: begin is_store = 1'b1; is_word = 1'b1; end
      default: valid = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      6'b000100: taken = Zero;
      6'b000101: taken = ~Zero;
      6'b000110: taken = rs_sign | rs_zero;
      6'b000111: taken = ~rs_sign & ~rs_zero;
      6'b000001: taken = rt[0] ? ~rs_sign : rs_sign;
      default:   taken = 1'b0;
    endcase
  end

  logic misaligned, io_space;
  assign misaligned = (is_half & bus.Alu_result[0]) | (is_word & (|bus.Alu_result[1:0]));
  assign io_space   = (bus.Alu_result[ADDR_W-1 -: IO_HI_W] == IO_HI_VAL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SINIT;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      code_q  <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt = cnt_q;
    code_nxt = code_q;
    Wir = 1'b0; PcWrite = 1'b0; Wpc = 2'b00; Waluresult = 1'b0; RegWrite = 1'b0;
    Busy = 1'b0; Exc = 1'b0; ExcCode = 5'd0;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.IORead = 1'b0; bus.IOWrite = 1'b0;
    case (state_q)
      SINIT: state_nxt = SIF;
      SIF: begin
        Wir = 1'b1; PcWrite = 1'b1;
        state_nxt = SID;
      end
      SID: begin
        if (!valid) begin
          state_nxt = SEXC; code_nxt = 5'd10;
        end else if (is_sys) begin
          state_nxt = SEXC; code_nxt = 5'd8;
        end else if (is_brk) begin
          state_nxt = SEXC; code_nxt = 5'd9;
        end else if (is_jump) begin
          PcWrite   = 1'b1;
          Wpc       = jmp_reg ? 2'b11 : 2'b10;
          state_nxt = jmp_link ? SWB : SIF;
        end else begin
          state_nxt = SEX;
        end
      end
      SEX: begin
        Waluresult = 1'b1;
        if (is_branch) begin
          if (taken) begin PcWrite = 1'b1; Wpc = 2'b01; end
          state_nxt = br_link ? SWB : SIF;
        end else if (is_load || is_store) begin
          if (misaligned) begin
            state_nxt = SEXC; code_nxt = is_load ? 5'd4 : 5'd5;
          end else begin
            state_nxt = SMEM; cnt_nxt = '0;
          end
        end else if (is_md) begin
          state_nxt = SMD; cnt_nxt = CNT_W'(MD_CYCLES - 1);
        end else begin
          state_nxt = no_wb ? SIF : SWB;
        end
      end
      SMEM: begin
        Busy = 1'b1;
        bus.MemRead  = is_load  & ~io_space;
        bus.IORead   = is_load  &  io_space;
        bus.MemWrite = is_store & ~io_space;
        bus.IOWrite  = is_store &  io_space;
        // A late acknowledge on the final wait cycle still completes the access.
        if (bus.mem_ready) begin
          state_nxt = is_load ? SWB : SIF;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt = SEXC; code_nxt = 5'd7;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      SWB: begin
        RegWrite = 1'b1;
        state_nxt = SIF;
      end
      SMD: begin
        Busy = 1'b1;
        if (cnt_q == '0) state_nxt = SIF;
        else cnt_nxt = cnt_q - CNT_W'(1);
      end
      SEXC: begin
        Exc = 1'b1; ExcCode = code_q;
        state_nxt = SIF;
      end
      default: state_nxt = SINIT;
    endcase
    // Interrupts are only taken at instruction boundaries.
    if (state_nxt == SIF && ext_int) begin
      state_nxt = SEXC; code_nxt = 5'd0;
    end
  end

  assign state = state_q;
endmodule
